// File: rtl/conv1d_mac_sched.sv
// rtl/conv1d_mac_sched.sv - TAPS-tap 1D convolution scheduler driving one shared pipelined multiplier
// Holds coefficients and a sample window; issues one multiply per cycle and accumulates returned products.
module conv1d_mac_sched #(
  parameter int TAPS    = 4,
  parameter int DW      = 4,
  parameter int MUL_LAT = 1,
  parameter int ACC_W   = 10
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(TAPS)-1:0]  cfg_addr,
  input  logic [DW-1:0]            cfg_data,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  output logic                     in_ready,
  output logic [DW-1:0]            mul_a,
  output logic [DW-1:0]            mul_b,
  input  logic [2*DW-1:0]          mul_p,
  output logic                     out_valid,
  output logic [ACC_W-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     busy
);
  localparam int AW = $clog2(TAPS);
  localparam logic [AW-1:0] IDX_LAST = AW'(TAPS - 1);
  localparam logic [1:0]    DRN_LAST = 2'(MUL_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t               r_state, w_next;
  logic [DW-1:0]        r_coef [TAPS];
  logic [DW-1:0]        r_win  [TAPS];
  logic [ACC_W-1:0]     r_acc;
  logic [AW-1:0]        r_idx;
  logic [1:0]           r_dcnt;
  logic [MUL_LAT-1:0]   r_vpipe;
  logic                 w_idle, w_issue, w_accept, w_vout;

  assign w_idle   = (r_state == IDLE);
  assign w_issue  = (r_state == ISSUE);
  assign w_accept = w_idle && in_valid;
  // Marks the cycle in which the product of an issued tap is present on mul_p.
  assign w_vout   = r_vpipe[MUL_LAT-1];

  assign in_ready  = w_idle;
  assign busy      = !w_idle;
  assign out_valid = (r_state == OUT);
  assign out_data  = r_acc;
  assign mul_a     = w_issue ? r_win[r_idx]  : '0;
  assign mul_b     = w_issue ? r_coef[r_idx] : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)            w_next = ISSUE;
      ISSUE:   if (r_idx == IDX_LAST)   w_next = DRAIN;
      DRAIN:   if (r_dcnt == DRN_LAST)  w_next = OUT;
      OUT:     if (out_ready)           w_next = IDLE;
      default:                          w_next = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_idx   <= '0;
      r_dcnt  <= '0;
      r_vpipe <= '0;
      for (int i = 0; i < TAPS; i++) begin
        r_coef[i] <= '0;
        r_win[i]  <= '0;
      end
    end else begin
      r_state <= w_next;
      r_vpipe <= MUL_LAT'({r_vpipe, w_issue});

      // A write in the accepting cycle lands before the first tap is issued.
      if (w_idle && cfg_we)
        r_coef[cfg_addr] <= cfg_data;

      if (w_accept) begin
        for (int i = 1; i < TAPS; i++)
          r_win[i] <= r_win[i-1];
        r_win[0] <= in_data;
        r_acc    <= '0;
        r_idx    <= '0;
      end else begin
        if (w_idle && clr)
          for (int i = 0; i < TAPS; i++)
            r_win[i] <= '0;
        if (w_vout)
          r_acc <= r_acc + ACC_W'(mul_p);
      end

      if (w_issue) begin
        r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        r_dcnt <= '0;
      end else if (r_state == DRAIN) begin
        r_dcnt <= r_dcnt + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_conv1d_mac_sched.sv
// tb/tb_conv1d_mac_sched.sv - directed table-driven bench for conv1d_mac_sched
// Instance 0 uses MUL_LAT=1, instance 1 uses MUL_LAT=3; each has its own model multiplier.
module tb_conv1d_mac_sched;
  logic       ck;
  logic       rst       [2];
  logic       cfg_we    [2];
  logic [1:0] cfg_addr  [2];
  logic [3:0] cfg_data  [2];
  logic       clr       [2];
  logic       in_valid  [2];
  logic [3:0] in_data   [2];
  logic       in_ready  [2];
  logic [3:0] mul_a     [2];
  logic [3:0] mul_b     [2];
  logic [7:0] mul_p     [2];
  logic       out_valid [2];
  logic [9:0] out_data  [2];
  logic       out_ready [2];
  logic       busy      [2];

  int n_vec = 0;
  int n_bad = 0;

  initial ck = 1'b0;
  always #5 ck = ~ck;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [7:0] pp [L];
    always_ff @(posedge ck) begin
      pp[0] <= mul_a[g] * mul_b[g];
      for (int k = 1; k < L; k++) pp[k] <= pp[k-1];
    end
    assign mul_p[g] = pp[L-1];

    conv1d_mac_sched #(.TAPS(4), .DW(4), .MUL_LAT(L), .ACC_W(10)) u_dut (
      .ck(ck), .rst(rst[g]), .cfg_we(cfg_we[g]), .cfg_addr(cfg_addr[g]),
      .cfg_data(cfg_data[g]), .clr(clr[g]), .in_valid(in_valid[g]),
      .in_data(in_data[g]), .in_ready(in_ready[g]), .mul_a(mul_a[g]),
      .mul_b(mul_b[g]), .mul_p(mul_p[g]), .out_valid(out_valid[g]),
      .out_data(out_data[g]), .out_ready(out_ready[g]), .busy(busy[g])
    );
  end

  typedef struct {
    int         d;
    logic [3:0] s;
    int         exp;
    int         lat;
    int         hold;
    bit         cs;
    bit         ci;
    logic [1:0] ca;
    logic [3:0] cd;
    bit         pre15;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(int d, int s, int exp, int lat, int hold,
                              int cs, int ci, int ca, int cd, int p15);
    vec_t v;
    v.d = d; v.s = 4'(s); v.exp = exp; v.lat = lat; v.hold = hold;
    v.cs = (cs != 0); v.ci = (ci != 0); v.ca = 2'(ca); v.cd = 4'(cd);
    v.pre15 = (p15 != 0);
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(int d, int a, int v);
    @(negedge ck);
    cfg_we[d] = 1'b1; cfg_addr[d] = 2'(a); cfg_data[d] = 4'(v);
    @(negedge ck);
    cfg_we[d] = 1'b0;
  endtask

  task automatic flush(int d);
    @(negedge ck);
    clr[d] = 1'b1;
    @(negedge ck);
    clr[d] = 1'b0;
  endtask

  task automatic send(vec_t v);
    int d;
    int n;
    bit bad;
    d = v.d;
    @(negedge ck);
    chk("in_ready_idle", int'(in_ready[d]), 1);
    in_valid[d] = 1'b1; in_data[d] = v.s;
    if (v.cs) begin cfg_we[d] = 1'b1; cfg_addr[d] = v.ca; cfg_data[d] = v.cd; end
    @(posedge ck);
    @(negedge ck);
    in_valid[d] = 1'b0; cfg_we[d] = 1'b0;
    if (v.ci) begin cfg_we[d] = 1'b1; cfg_addr[d] = v.ca; cfg_data[d] = v.cd; end
    n = 0; bad = 1'b0;
    while (!out_valid[d] && n < 40) begin
      if (in_ready[d] || !busy[d]) bad = 1'b1;
      @(posedge ck); n++;
      @(negedge ck); cfg_we[d] = 1'b0;
    end
    chk("latency", n, v.lat);
    chk("busy_no_ready", int'(bad), 0);
    chk("out_data", int'(out_data[d]), v.exp);
    chk("mul_a_idle_in_out", int'(mul_a[d]), 0);
    bad = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge ck); @(negedge ck);
      if (!out_valid[d] || out_data[d] != 10'(v.exp) || in_ready[d]) bad = 1'b1;
    end
    if (v.hold > 0) chk("hold_stable", int'(bad), 0);
    out_ready[d] = 1'b1;
    @(posedge ck); @(negedge ck);
    out_ready[d] = 1'b0;
    chk("out_valid_drop", int'(out_valid[d]), 0);
    chk("in_ready_back", int'(in_ready[d]), 1);
  endtask

  initial begin
    int seen;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cfg_we[d] = 1'b0; cfg_addr[d] = '0; cfg_data[d] = '0;
      clr[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0;
    end

    //              d  s  exp lat hold cs ci ca cd p15
    tbl[0]  = mk(0, 2,   2, 5, 10, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 5,   9, 5,  0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 6,  22, 5,  0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1,  36, 5,  0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 2,   2, 7,  0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 5,   9, 7,  0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 6,  22, 7,  0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1,  36, 7,  3, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 5,  45, 5,  0, 0, 1, 0, 7, 0);
    tbl[9]  = mk(0, 3,   3, 5,  0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 1,  28, 5,  0, 1, 0, 1, 9, 0);
    tbl[11] = mk(0, 15, 225, 5, 0, 0, 0, 0, 0, 1);
    tbl[12] = mk(0, 15, 450, 5, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 15, 675, 5, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 15, 900, 5, 0, 0, 0, 0, 0, 0);

    @(negedge ck); @(negedge ck);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge ck);
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", int'(out_valid[d]), 0);
      chk("rst_out_data",  int'(out_data[d]), 0);
      chk("rst_in_ready",  int'(in_ready[d]), 1);
      chk("rst_busy",      int'(busy[d]), 0);
      chk("rst_mul_ab",    int'({mul_a[d], mul_b[d]}), 0);
    end

    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 4; a++) wr(d, a, a + 1);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].pre15) begin
        for (int a = 0; a < 4; a++) wr(tbl[i].d, a, 15);
        flush(tbl[i].d);
      end
      if (i == 9) flush(tbl[i].d);
      send(tbl[i]);
    end

    flush(0);
    send(mk(0, 2, 30, 5, 0, 0, 0, 0, 0, 0));
    @(negedge ck);
    in_valid[0] = 1'b1; in_data[0] = 4'd5;
    @(posedge ck); @(negedge ck);
    in_valid[0] = 1'b0;
    @(negedge ck);
    rst[0] = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ck);
      if (out_valid[0]) seen = 1;
    end
    rst[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge ck);
      if (out_valid[0]) seen = 1;
    end
    chk("no_partial_result", seen, 0);
    chk("post_rst_out_data", int'(out_data[0]), 0);
    chk("post_rst_in_ready", int'(in_ready[0]), 1);
    chk("post_rst_busy",     int'(busy[0]), 0);
    send(mk(0, 4, 0, 5, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
